// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared definitions for the PE output paths: the accumulator
//               FSM state encoding, default datapath widths and the signed
//               saturation limits.
// Revision    : 1.0  initial release
// ============================================================================
package pe_pkg;

   localparam int PE_DATA_W = 32;
   localparam int PE_LEN_W  = 16;

   // Accumulator FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   // Signed 32-bit saturation limits
   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/pe_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_accumulator_if
// Description : Job configuration, input-beat and result handshake bundle of
//               the PE accumulator.
//               master : job/beat source and result sink (drives start, cfg_*,
//                        in_valid, in_data, out_ready)
//               slave  : the accumulator (drives in_ready, out_*, busy, done)
// Revision    : 1.0  initial release
// ============================================================================
interface pe_accumulator_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) ();

   logic              start;
   logic [LEN_W-1:0]  cfg_len;
   logic [DATA_W-1:0] cfg_bias;
   logic              cfg_relu;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_sat;
   logic              out_ready;
   logic              busy;
   logic              done;

   modport master (
      output start, cfg_len, cfg_bias, cfg_relu, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat, busy, done
   );

   modport slave (
      input  start, cfg_len, cfg_bias, cfg_relu, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/pe_acc_post.sv
`default_nettype none
// ============================================================================
// Module      : pe_acc_post
// Description : Combinational post-processing of a wide signed accumulator:
//               optional ReLU followed by signed saturation to DATA_W bits.
//   acc_i  : ACC_W-bit two's complement value
//   relu_i : clamp negative values to zero before saturation
//   data_o : DATA_W-bit signed result
//   sat_o  : result was clamped to the signed limits
// Revision    : 1.0  initial release
// ============================================================================
module pe_acc_post
   import pe_pkg::*;
#(
   parameter int DATA_W = PE_DATA_W,
   parameter int ACC_W  = PE_DATA_W + PE_LEN_W + 1
) (
   input  logic [ACC_W-1:0]  acc_i,
   input  logic              relu_i,
   output logic [DATA_W-1:0] data_o,
   output logic              sat_o
);

   logic [ACC_W-1:0]      w_x;
   logic [ACC_W-DATA_W:0] w_top;

   assign w_x = (relu_i && acc_i[ACC_W-1]) ? '0 : acc_i;

   // The value fits in DATA_W signed bits only when every bit from the
   // result sign bit upward is a copy of the same value.
   assign w_top = w_x[ACC_W-1:DATA_W-1];

   always_comb begin
      data_o = w_x[DATA_W-1:0];
      sat_o  = 1'b0;
      if (!((w_top == '0) || (w_top == '1))) begin
         sat_o  = 1'b1;
         data_o = w_x[ACC_W-1] ? DATA_W'(SAT_MIN) : DATA_W'(SAT_MAX);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pe_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : pe_accumulator
// Description : Sums cfg_len signed beats on top of a signed bias, applies
//               optional ReLU and 32-bit signed saturation, and presents one
//               result per job on a valid/ready port.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : pe_accumulator_if slave (start/cfg_*, in_* beats, out_* result,
//          busy, done)
// Revision    : 1.0  initial release
// ============================================================================
module pe_accumulator
   import pe_pkg::*;
#(
   parameter int DATA_W = PE_DATA_W,
   parameter int LEN_W  = PE_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   pe_accumulator_if.slave   bus
);

   // One extra bit beyond DATA_W+LEN_W so the sum of any legal job can't wrap
   localparam int ACC_W = DATA_W + LEN_W + 1;

   logic [1:0]        state_q,     state_d;
   logic [ACC_W-1:0]  acc_q,       acc_d;
   logic [LEN_W-1:0]  count_q,     count_d;
   logic [LEN_W-1:0]  len_q,       len_d;
   logic              relu_q,      relu_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_sat_q,   out_sat_d;
   logic              done_q,      done_d;

   logic [ACC_W-1:0]  w_bias_ext;
   logic [ACC_W-1:0]  w_sum;
   logic [LEN_W-1:0]  w_count_inc;
   logic [ACC_W-1:0]  w_post_in;
   logic              w_post_relu;
   logic [DATA_W-1:0] w_post_data;
   logic              w_post_sat;

   assign w_bias_ext  = {{(ACC_W-DATA_W){bus.cfg_bias[DATA_W-1]}}, bus.cfg_bias};
   assign w_sum       = acc_q + {{(ACC_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
   assign w_count_inc = count_q + LEN_W'(1);

   // One post stage serves both result sources: a zero-length job finishes
   // straight from IDLE with the bias, otherwise the last beat's sum is used.
   assign w_post_in   = (state_q == ST_IDLE) ? w_bias_ext   : w_sum;
   assign w_post_relu = (state_q == ST_IDLE) ? bus.cfg_relu : relu_q;

   pe_acc_post #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_post (
      .acc_i  (w_post_in),
      .relu_i (w_post_relu),
      .data_o (w_post_data),
      .sat_o  (w_post_sat)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      len_d       = len_q;
      relu_d      = relu_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               len_d   = bus.cfg_len;
               relu_d  = bus.cfg_relu;
               acc_d   = w_bias_ext;
               count_d = '0;
               if (bus.cfg_len == '0) begin
                  state_d     = ST_OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = w_post_data;
                  out_sat_d   = w_post_sat;
               end else begin
                  state_d = ST_ACC;
               end
            end
         end
         ST_ACC: begin
            if (bus.in_valid) begin
               acc_d   = w_sum;
               count_d = w_count_inc;
               if (w_count_inc == len_q) begin
                  state_d     = ST_OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = w_post_data;
                  out_sat_d   = w_post_sat;
               end
            end
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         len_q       <= '0;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         len_q       <= len_d;
         relu_q      <= relu_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_ACC);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_accumulator
// Description : Self-checking bench for pe_accumulator. Inputs change and
//               outputs are sampled on the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pe_accumulator;
   import pe_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic        sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   int   bq[$];

   always #5 clk = ~clk;

   pe_accumulator_if #(.DATA_W(32), .LEN_W(16)) bus ();

   pe_accumulator #(.DATA_W(32), .LEN_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference: bias plus all queued beats, ReLU, then signed saturation
   function automatic exp_t model(int bias, bit relu);
      exp_t   e;
      longint s = longint'(bias);
      foreach (bq[i]) s += longint'(bq[i]);
      if (relu && s < 0) s = 0;
      if (s > 64'sd2147483647) begin
         e.data = SAT_MAX; e.sat = 1'b1;
      end else if (s < -64'sd2147483648) begin
         e.data = SAT_MIN; e.sat = 1'b1;
      end else begin
         e.data = s[31:0]; e.sat = 1'b0;
      end
      return e;
   endfunction

   task automatic do_start(int len, int bias, bit relu);
      bus.start    = 1'b1;
      bus.cfg_len  = len[15:0];
      bus.cfg_bias = bias;
      bus.cfg_relu = relu;
      sb.push_back(model(bias, relu));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_beats(int gap);
      foreach (bq[i]) begin
         bus.in_valid = 1'b1;
         bus.in_data  = bq[i];
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (i != bq.size() - 1) repeat (gap) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      bus.start = 0; bus.cfg_len = '0; bus.cfg_bias = '0; bus.cfg_relu = 0;
      bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_sat, bus.in_ready, bus.busy, bus.done} !== 37'd0) begin
         failures++;
         $display("FAIL reset_state: got valid=%b data=%h sat=%b in_ready=%b busy=%b done=%b required all zero",
                  bus.out_valid, bus.out_data, bus.out_sat, bus.in_ready, bus.busy, bus.done);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      exp_t e;
      bq = '{1, 2, 3, 4};
      do_start(4, 10, 0);
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_acc_state: busy=%b in_ready=%b required 1 1", bus.busy, bus.in_ready);
      end
      send_beats(0);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
         failures++;
         $display("FAIL basic_result: got v=%b d=%h s=%b required v=1 d=%h s=%b",
                  bus.out_valid, bus.out_data, bus.out_sat, e.data, e.sat);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_done: done=%b valid=%b busy=%b required 1 0 0", bus.done, bus.out_valid, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL basic_done_pulse: done=%b required 0", bus.done);
      end
   endtask

   task automatic test_stall_backpressure;
      exp_t e;
      bq = '{5, -7, 1};
      do_start(3, 0, 0);
      send_beats(2);
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%b in_ready=%b required v=1 d=%h s=%b in_ready=0",
                     c, bus.out_valid, bus.out_data, bus.out_sat, bus.in_ready, e.data, e.sat);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.done !== 1'b1) begin
         failures++;
         $display("FAIL stall_done: done=%b required 1", bus.done);
      end
   endtask

   task automatic test_relu_len0;
      exp_t e;
      bq = '{-5, -5, 2};
      do_start(3, 0, 1);
      send_beats(0);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
         failures++;
         $display("FAIL relu_result: got v=%b d=%h s=%b required v=1 d=%h s=%b",
                  bus.out_valid, bus.out_data, bus.out_sat, e.data, e.sat);
      end
      bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
      bq = {};
      do_start(0, -3, 0);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
         failures++;
         $display("FAIL len0_result: got v=%b d=%h s=%b required v=1 d=%h s=%b",
                  bus.out_valid, bus.out_data, bus.out_sat, e.data, e.sat);
      end
      bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
   endtask

   task automatic test_saturation;
      exp_t e;
      for (int j = 0; j < 2; j++) begin
         if (j == 0) bq = '{32'h7FFF_FFFF, 32'h0000_0001};
         else        bq = '{32'h8000_0000, 32'hFFFF_FFFF};
         do_start(2, 0, 0);
         send_beats(0);
         e = sb.pop_front();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
            failures++;
            $display("FAIL sat_result[%0d]: got v=%b d=%h s=%b required v=1 d=%h s=%b",
                     j, bus.out_valid, bus.out_data, bus.out_sat, e.data, e.sat);
         end
         bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_ignored;
      exp_t e;
      bq = '{1, 2, 3};
      do_start(3, 100, 0);
      // Reconfigure right after start: must not affect this job
      bus.cfg_len = 16'd1; bus.cfg_bias = 555; bus.cfg_relu = 1'b1;
      bus.in_valid = 1'b1; bus.in_data = 1;
      @(negedge clk);
      bus.in_data = 2; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.in_data = 3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
         failures++;
         $display("FAIL ignore_cfg_result: got v=%b d=%h s=%b required v=1 d=%h s=%b",
                  bus.out_valid, bus.out_data, bus.out_sat, e.data, e.sat);
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL ignore_start_out: got v=%b d=%h busy=%b required v=1 d=%h busy=1",
                  bus.out_valid, bus.out_data, bus.busy, e.data);
      end
      bus.out_ready = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start_handshake: busy=%b valid=%b required 0 0", bus.busy, bus.out_valid);
      end
      // Beats offered in IDLE must not be consumed
      bus.in_valid = 1'b1; bus.in_data = 1000;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_in_valid: in_ready=%b busy=%b required 0 0", bus.in_ready, bus.busy);
      end
      bus.in_valid = 1'b0;
      bq = '{7};
      do_start(1, 0, 0);
      send_beats(0);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
         failures++;
         $display("FAIL idle_not_consumed: got v=%b d=%h s=%b required v=1 d=%h s=%b",
                  bus.out_valid, bus.out_data, bus.out_sat, e.data, e.sat);
      end
      bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_midjob;
      exp_t e;
      bus.cfg_len = 16'd8; bus.cfg_bias = 0; bus.cfg_relu = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1; bus.in_data = 50;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_sat, bus.in_ready, bus.busy, bus.done} !== 37'd0) begin
         failures++;
         $display("FAIL reset_midjob: got valid=%b data=%h sat=%b in_ready=%b busy=%b done=%b required all zero",
                  bus.out_valid, bus.out_data, bus.out_sat, bus.in_ready, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bq = '{1, 1};
      do_start(2, 1, 0);
      send_beats(0);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
         failures++;
         $display("FAIL post_reset_job: got v=%b d=%h s=%b required v=1 d=%h s=%b",
                  bus.out_valid, bus.out_data, bus.out_sat, e.data, e.sat);
      end
      bus.out_ready = 1'b1; @(negedge clk); bus.out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL final_idle: busy=%b pending=%0d required busy=0 pending=0", bus.busy, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_backpressure();
      test_relu_len0();
      test_saturation();
      test_ignored();
      test_reset_midjob();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
